// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one 8x8 unsigned multiplier between NUM_REQ requesters,
// with a 3-state capture/multiply/respond sequence and a tagged response channel.
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            rsp_result,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   rr_ptr_d;
  logic [7:0]        op_a_q;
  logic [7:0]        op_b_q;
  logic [ID_W-1:0]   id_q;
  logic [15:0]       rsp_result_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic              rsp_valid_q;
  logic              busy_q;

  logic              grant_vld_s;
  logic [ID_W-1:0]   grant_idx_s;
  logic [ID_W-1:0]   cand_s;
  logic [7:0]        sel_a_s;
  logic [7:0]        sel_b_s;
  logic [15:0]       product_s;

  // (base + off) mod NUM_REQ for off < NUM_REQ
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return s[ID_W-1:0];
  endfunction

  // Shift-add partial-product sum; stands in for the shared 8x8 tree multiplier
  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = 16'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc + ({8'd0, a} << i);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  // Round-robin search starting at rr_ptr_q
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = wrap_idx(rr_ptr_q, k);
      if (!grant_vld_s && req_valid[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  assign rr_ptr_d = wrap_idx(grant_idx_s, 1);

  // Ready is only offered while idle, to the granted requester
  always_comb begin
    req_ready = '0;
    if ((state_q == S_IDLE) && grant_vld_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Operand slice of the granted requester
  always_comb begin
    sel_a_s = 8'd0;
    sel_b_s = 8'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == ID_W'(i)) begin
        sel_a_s = req_a[8*i +: 8];
        sel_b_s = req_b[8*i +: 8];
      end else begin
        sel_a_s = sel_a_s;
      end
    end
  end

  assign product_s = mul8(op_a_q, op_b_q);

  // Capture / multiply / respond sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      op_a_q       <= 8'd0;
      op_b_q       <= 8'd0;
      id_q         <= '0;
      rsp_result_q <= 16'd0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld_s) begin
            op_a_q   <= sel_a_s;
            op_b_q   <= sel_b_s;
            id_q     <= grant_idx_s;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b1;
            state_q  <= S_MUL;
          end
        end
        S_MUL: begin
          rsp_result_q <= product_s;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomised and directed bench for mul_share_arbiter: a round-robin/latency reference
// model predicts grants and pushes expected products; a monitor pops and compares responses.
module tb_mul_share_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = 4'd0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int m_state = 0;   // 0: can accept, 1: product pending, 2: response offered
  int m_ptr = 0;
  int exp_id_q[$];
  logic [15:0] exp_p_q[$];
  int pushed = 0;
  int popped = 0;

  mul_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, check ready/busy/valid against the model, advance the model
  task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                      input logic rr, output int g);
    logic [3:0] exp_ready;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
    #1;
    g = -1;
    exp_ready = 4'd0;
    if (m_state == 0) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
    chk("busy", {31'd0, busy}, {31'd0, m_state != 0});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_state == 2});
    if (g >= 0) begin
      exp_id_q.push_back(g);
      exp_p_q.push_back(16'(a[8*g +: 8]) * 16'(b[8*g +: 8]));
      pushed++;
      m_ptr = (g + 1) % N;
      m_state = 1;
    end else if (m_state == 1) begin
      m_state = 2;
    end else if (m_state == 2 && rr) begin
      m_state = 0;
    end
  endtask

  task automatic idle_cycles(input int n);
    int g;
    repeat (n) step(4'd0, 32'd0, 32'd0, 1'b1, g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'd0; req_a = $urandom; req_b = $urandom; rsp_ready = 1'($urandom);
    m_state = 0; m_ptr = 0;
    exp_id_q.delete(); exp_p_q.delete();
    pushed = 0; popped = 0;
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    req_a = $urandom; req_b = $urandom;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  // Response monitor: every offered response must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && rsp_valid) begin
        if (exp_id_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_rsp: got id %0d result %h, required no response", rsp_id, rsp_result);
        end else begin
          chk("rsp_id", {30'd0, rsp_id}, exp_id_q[0]);
          chk("rsp_result", {16'd0, rsp_result}, {16'd0, exp_p_q[0]});
          if (rsp_ready) begin
            void'(exp_id_q.pop_front());
            void'(exp_p_q.pop_front());
            popped++;
          end
        end
      end
    end
  end

  initial begin
    int g;
    int txns;
    int cyc;
    logic [3:0] pv;
    logic [7:0] pa [N];
    logic [7:0] pb [N];
    logic [31:0] a_pk, b_pk;

    do_reset();

    // Single request, maximum operands
    step(4'b0100, 32'h00FF_0000, 32'h00FF_0000, 1'b1, g);
    idle_cycles(3);

    // Round robin with all requesters continuously valid
    do_reset();
    repeat (15) step(4'b1111, 32'h0403_0201, 32'h1010_1010, 1'b1, g);
    idle_cycles(1);

    // Backpressure: response held 5+ cycles while another requester waits
    step(4'b0001, 32'h0000_0080, 32'h0000_0002, 1'b1, g);
    step(4'b0010, 32'h0000_3300, 32'h0000_0200, 1'b0, g);
    repeat (5) step(4'b0010, 32'h0000_3300, 32'h0000_0200, 1'b0, g);
    step(4'b0010, 32'h0000_3300, 32'h0000_0200, 1'b1, g);
    step(4'b0010, 32'h0000_3300, 32'h0000_0200, 1'b1, g);
    idle_cycles(3);

    // Reset while the product is in flight: response must never appear
    step(4'b0010, 32'h0000_0F00, 32'h0000_0F00, 1'b1, g);
    do_reset();
    step(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, g);
    idle_cycles(3);

    // Operand corners
    step(4'b0001, 32'h0000_0000, 32'h0000_00AB, 1'b1, g);
    idle_cycles(2);
    step(4'b0100, 32'h0001_0000, 32'h00FF_0000, 1'b1, g);
    idle_cycles(2);
    step(4'b1000, 32'hFF00_0000, 32'h0100_0000, 1'b1, g);
    idle_cycles(3);

    // Randomised traffic with held requests and random response backpressure
    pv = 4'd0;
    for (int i = 0; i < N; i++) begin pa[i] = 8'd0; pb[i] = 8'd0; end
    txns = 0;
    cyc = 0;
    while (txns < 1000 && cyc < 20000) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1; pa[i] = rnd_op(); pb[i] = rnd_op();
        end
      end
      for (int i = 0; i < N; i++) begin
        a_pk[8*i +: 8] = pa[i];
        b_pk[8*i +: 8] = pb[i];
      end
      step(pv, a_pk, b_pk, ($urandom_range(0, 3) != 0), g);
      if (g >= 0) begin
        pv[g] = 1'b0;
        txns++;
      end
      cyc++;
    end
    if (txns < 1000) begin
      n_cmp++; n_err++;
      $display("FAIL random_budget: got %0d transactions, required 1000", txns);
    end
    idle_cycles(6);
    chk("outstanding", exp_id_q.size(), 32'd0);
    chk("rsp_count", popped, pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
